// File: rtl/fa_bist_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fa_bist_pkg
// Description : Shared types, constants and golden model for the one-bit
//               full-adder built-in self-test sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fa_bist_pkg;

    // Sequencer states; the width is fixed so the encoding is explicit.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Exhaustive sweep over every {x,y,z} combination.
    localparam int unsigned FA_NUM_VECTORS = 8;

    // Reference full adder: returns {carry, sum}.
    function automatic logic [1:0] fa_golden(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fa_bist.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fa_bist
// Description : Self-test sequencer for an external one-bit full adder.
//               Sweeps all eight input vectors, holds each for HOLD_CYCLES
//               cycles, samples {C,S} once, compares against the golden
//               model and reports verdict, error count and first failure.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_bist
    import fa_bist_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             x,
    output logic             y,
    output logic             z,
    input  logic             c_in,
    input  logic             s_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       first_fail_vec
);

    localparam logic [7:0]       C_HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0]       C_LAST_VEC  = 3'(FA_NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0] C_ERR_MAX   = '1;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_vec;
    logic [7:0]       r_hold;
    logic [ERR_W-1:0] r_err;
    logic [2:0]       r_first;
    logic             r_pass;
    logic             r_busy;
    logic             r_done;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;

    // The adder is driven straight from r_vec, so its response is a pure
    // function of the current vector by the time SAMPLE compares it.
    assign w_mismatch = ({c_in, s_in} != fa_golden(r_vec[2], r_vec[1], r_vec[0]));
    assign w_err_next = (w_mismatch && (r_err != C_ERR_MAX)) ? r_err + ERR_W'(1) : r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so it never queues.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_APPLY;
            ST_APPLY:  if (r_hold == C_HOLD_LAST) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = (r_vec == C_LAST_VEC) ? ST_DONE : ST_APPLY;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Datapath and registered Moore outputs, derived from the next state so
    // busy/done line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec   <= 3'd0;
            r_hold  <= 8'd0;
            r_err   <= '0;
            r_first <= 3'd0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= (w_next == ST_APPLY) || (w_next == ST_SAMPLE);
            r_done <= (w_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_vec   <= 3'd0;
                        r_hold  <= 8'd0;
                        r_err   <= '0;
                        r_first <= 3'd0;
                        r_pass  <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    r_hold <= r_hold + 8'd1;
                end
                ST_SAMPLE: begin
                    r_err <= w_err_next;
                    if (w_mismatch && (r_err == '0)) begin
                        r_first <= r_vec;
                    end
                    // Wraps 7 -> 0 so DONE and IDLE drive vector 0.
                    r_vec  <= r_vec + 3'd1;
                    r_hold <= 8'd0;
                    if (r_vec == C_LAST_VEC) begin
                        r_pass <= (w_err_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign x              = r_vec[2];
    assign y              = r_vec[1];
    assign z              = r_vec[0];
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_fail_vec = r_first;

endmodule
`default_nettype wire

// File: tb/tb_fa_bist.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fa_bist
// Description : Directed self-checking bench for fa_bist. Three instances:
//               A (HOLD=2, ERR_W=4) with a selectable adder fault,
//               B (HOLD=2, ERR_W=2) with an inverted-sum adder,
//               C (HOLD=1, ERR_W=4) with a correct adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fa_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b, start_c;
    int   fault_mode;  // 0 correct, 1 carry stuck at 0, 2 sum inverted

    logic       a_x, a_y, a_z, a_c, a_s, a_busy, a_done, a_pass;
    logic [3:0] a_err;
    logic [2:0] a_ff;
    logic       b_x, b_y, b_z, b_c, b_s, b_busy, b_done, b_pass;
    logic [1:0] b_err;
    logic [2:0] b_ff;
    logic       c_x, c_y, c_z, c_c, c_s, c_busy, c_done, c_pass;
    logic [3:0] c_err;
    logic [2:0] c_ff;

    // External full-adder models.
    assign a_c = (fault_mode == 1) ? 1'b0 : ((a_x & a_y) | (a_x & a_z) | (a_y & a_z));
    assign a_s = a_x ^ a_y ^ a_z ^ (fault_mode == 2);
    assign b_c = (b_x & b_y) | (b_x & b_z) | (b_y & b_z);
    assign b_s = ~(b_x ^ b_y ^ b_z);
    assign c_c = (c_x & c_y) | (c_x & c_z) | (c_y & c_z);
    assign c_s = c_x ^ c_y ^ c_z;

    fa_bist #(.HOLD_CYCLES(2), .ERR_W(4)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .x(a_x), .y(a_y), .z(a_z),
        .c_in(a_c), .s_in(a_s), .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_count(a_err), .first_fail_vec(a_ff));

    fa_bist #(.HOLD_CYCLES(2), .ERR_W(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .x(b_x), .y(b_y), .z(b_z),
        .c_in(b_c), .s_in(b_s), .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_count(b_err), .first_fail_vec(b_ff));

    fa_bist #(.HOLD_CYCLES(1), .ERR_W(4)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .x(c_x), .y(c_y), .z(c_z),
        .c_in(c_c), .s_in(c_s), .busy(c_busy), .done(c_done), .pass(c_pass),
        .err_count(c_err), .first_fail_vec(c_ff));

    int total = 0;
    int bad   = 0;

    int cap_vec  [0:63];
    int cap_busy [0:63];
    int cap_done [0:63];
    int cap_pass [0:63];
    int cap_err  [0:63];
    int cap_ff   [0:63];

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    // Pulse start (sampled at edge t) and record outputs of cycles t+1..t+ncyc.
    // pert_start / pert_rst: cycle in which an extra start / rst is raised.
    task automatic capture(input int sel, input int ncyc, input int pert_start,
                           input int pert_rst, input bit hold);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) set_start(sel, 1'b0);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            case (sel)
                0: begin
                    cap_vec[i] = {a_x, a_y, a_z}; cap_busy[i] = a_busy; cap_done[i] = a_done;
                    cap_pass[i] = a_pass; cap_err[i] = a_err; cap_ff[i] = a_ff;
                end
                1: begin
                    cap_vec[i] = {b_x, b_y, b_z}; cap_busy[i] = b_busy; cap_done[i] = b_done;
                    cap_pass[i] = b_pass; cap_err[i] = b_err; cap_ff[i] = b_ff;
                end
                default: begin
                    cap_vec[i] = {c_x, c_y, c_z}; cap_busy[i] = c_busy; cap_done[i] = c_done;
                    cap_pass[i] = c_pass; cap_err[i] = c_err; cap_ff[i] = c_ff;
                end
            endcase
            if (pert_start == i) set_start(sel, 1'b1);
            else if (!hold) set_start(sel, 1'b0);
            rst = (pert_rst == i);
        end
        @(negedge clk);
        set_start(sel, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({a_x, a_y, a_z, a_busy, a_done, a_pass, a_err, a_ff} !== 14'd0) begin
            bad++; $display("FAIL reset_a got=%b exp=0", {a_x, a_y, a_z, a_busy, a_done, a_pass, a_err, a_ff});
        end
        total++;
        if ({b_x, b_y, b_z, b_busy, b_done, b_pass, b_err, b_ff} !== 11'd0) begin
            bad++; $display("FAIL reset_b got=%b exp=0", {b_x, b_y, b_z, b_busy, b_done, b_pass, b_err, b_ff});
        end
        total++;
        if ({c_x, c_y, c_z, c_busy, c_done, c_pass, c_err, c_ff} !== 14'd0) begin
            bad++; $display("FAIL reset_c got=%b exp=0", {c_x, c_y, c_z, c_busy, c_done, c_pass, c_err, c_ff});
        end
        rst = 1'b0;
    endtask

    // HOLD=2 sweep shape: vector k in cycles 3k+1..3k+3, done only at 25.
    task automatic check_sweep_h2(input string name, input int exp_pass, input int exp_err,
                                  input int exp_ff);
        for (int i = 1; i <= 24; i++) begin
            total++;
            if (cap_vec[i] !== (i - 1) / 3 || cap_busy[i] !== 1 || cap_done[i] !== 0) begin
                bad++;
                $display("FAIL %s_vec cyc=%0d got vec=%0d busy=%0d done=%0d exp vec=%0d busy=1 done=0",
                         name, i, cap_vec[i], cap_busy[i], cap_done[i], (i - 1) / 3);
            end
        end
        total++;
        if (cap_done[25] !== 1 || cap_busy[25] !== 0 || cap_vec[25] !== 0) begin
            bad++;
            $display("FAIL %s_done cyc=25 got done=%0d busy=%0d vec=%0d exp done=1 busy=0 vec=0",
                     name, cap_done[25], cap_busy[25], cap_vec[25]);
        end
        total++;
        if (cap_pass[25] !== exp_pass || cap_err[25] !== exp_err ||
            (exp_err != 0 && cap_ff[25] !== exp_ff)) begin
            bad++;
            $display("FAIL %s_result got pass=%0d err=%0d ff=%0d exp pass=%0d err=%0d ff=%0d",
                     name, cap_pass[25], cap_err[25], cap_ff[25], exp_pass, exp_err, exp_ff);
        end
        total++;
        if (cap_done[26] !== 0 || cap_busy[26] !== 0) begin
            bad++;
            $display("FAIL %s_after cyc=26 got done=%0d busy=%0d exp 0 0", name, cap_done[26], cap_busy[26]);
        end
    endtask

    task automatic test_correct();
        fault_mode = 0;
        capture(0, 30, 0, 0, 1'b0);
        check_sweep_h2("correct", 1, 0, 0);
        total++;
        if (cap_pass[30] !== 1) begin
            bad++; $display("FAIL pass_sticky got=%0d exp=1", cap_pass[30]);
        end
    endtask

    task automatic test_carry_stuck();
        fault_mode = 1;
        capture(0, 26, 0, 0, 1'b0);
        total++;
        if (cap_err[12] !== 0 || cap_err[13] !== 1 || cap_ff[13] !== 3) begin
            bad++;
            $display("FAIL carry_first got err12=%0d err13=%0d ff=%0d exp 0 1 3",
                     cap_err[12], cap_err[13], cap_ff[13]);
        end
        check_sweep_h2("carry", 0, 4, 3);
    endtask

    task automatic test_restart_clears();
        fault_mode = 0;
        capture(0, 26, 0, 0, 1'b0);
        total++;
        if (cap_err[1] !== 0 || cap_ff[1] !== 0 || cap_pass[1] !== 0) begin
            bad++;
            $display("FAIL restart_clear got err=%0d ff=%0d pass=%0d exp 0 0 0",
                     cap_err[1], cap_ff[1], cap_pass[1]);
        end
        check_sweep_h2("restart", 1, 0, 0);
    endtask

    task automatic test_saturate();
        capture(1, 26, 0, 0, 1'b0);
        total++;
        if (cap_err[7] !== 2 || cap_err[10] !== 3 || cap_err[13] !== 3) begin
            bad++;
            $display("FAIL sat_progress got err7=%0d err10=%0d err13=%0d exp 2 3 3",
                     cap_err[7], cap_err[10], cap_err[13]);
        end
        check_sweep_h2("sat", 0, 3, 0);
    endtask

    task automatic test_start_ignored();
        int n_done;
        fault_mode = 0;
        capture(0, 40, 7, 0, 1'b0);
        n_done = 0;
        for (int i = 1; i <= 40; i++) n_done += cap_done[i];
        total++;
        if (n_done !== 1) begin
            bad++; $display("FAIL ignored_done_count got=%0d exp=1", n_done);
        end
        total++;
        if (cap_busy[30] !== 0 || cap_busy[40] !== 0) begin
            bad++; $display("FAIL ignored_requeue got busy30=%0d busy40=%0d exp 0 0", cap_busy[30], cap_busy[40]);
        end
        check_sweep_h2("ignored", 1, 0, 0);
    endtask

    task automatic test_reset_mid();
        int n_done;
        fault_mode = 1;
        capture(0, 40, 0, 15, 1'b0);
        total++;
        if (cap_err[15] !== 1 || cap_busy[15] !== 1 || cap_vec[15] !== 4) begin
            bad++;
            $display("FAIL rstmid_pre got err=%0d busy=%0d vec=%0d exp 1 1 4",
                     cap_err[15], cap_busy[15], cap_vec[15]);
        end
        total++;
        if (cap_vec[16] !== 0 || cap_busy[16] !== 0 || cap_done[16] !== 0 ||
            cap_pass[16] !== 0 || cap_err[16] !== 0 || cap_ff[16] !== 0) begin
            bad++;
            $display("FAIL rstmid_state got vec=%0d busy=%0d done=%0d pass=%0d err=%0d ff=%0d exp all 0",
                     cap_vec[16], cap_busy[16], cap_done[16], cap_pass[16], cap_err[16], cap_ff[16]);
        end
        n_done = 0;
        for (int i = 16; i <= 40; i++) n_done += cap_done[i] + cap_busy[i];
        total++;
        if (n_done !== 0) begin
            bad++; $display("FAIL rstmid_quiet got=%0d exp=0", n_done);
        end
        fault_mode = 0;
        capture(0, 26, 0, 0, 1'b0);
        check_sweep_h2("rstmid_new", 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        fault_mode = 0;
        capture(0, 40, 0, 0, 1'b1);
        check_sweep_h2("b2b", 1, 0, 0);
        total++;
        if (cap_busy[27] !== 1 || cap_vec[27] !== 0 || cap_vec[30] !== 1 || cap_pass[27] !== 0) begin
            bad++;
            $display("FAIL b2b_restart got busy27=%0d vec27=%0d vec30=%0d pass27=%0d exp 1 0 1 0",
                     cap_busy[27], cap_vec[27], cap_vec[30], cap_pass[27]);
        end
        repeat (40) @(posedge clk);
    endtask

    task automatic test_hold1();
        capture(2, 20, 0, 0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            total++;
            if (cap_vec[i] !== (i - 1) / 2 || cap_busy[i] !== 1 || cap_done[i] !== 0) begin
                bad++;
                $display("FAIL hold1_vec cyc=%0d got vec=%0d busy=%0d done=%0d exp vec=%0d busy=1 done=0",
                         i, cap_vec[i], cap_busy[i], cap_done[i], (i - 1) / 2);
            end
        end
        total++;
        if (cap_done[17] !== 1 || cap_pass[17] !== 1 || cap_err[17] !== 0 || cap_done[18] !== 0) begin
            bad++;
            $display("FAIL hold1_done got done17=%0d pass=%0d err=%0d done18=%0d exp 1 1 0 0",
                     cap_done[17], cap_pass[17], cap_err[17], cap_done[18]);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start_a    = 1'b0;
        start_b    = 1'b0;
        start_c    = 1'b0;
        fault_mode = 0;
        test_reset();
        test_correct();
        test_carry_stuck();
        test_restart_clears();
        test_saturate();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_hold1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
